// File: rtl/rf_write_arbiter_if.sv
// Writeback request bundle between the two requesters and the register-file
// write arbiter.
//
// Handshake: a requester raises valid with addr/data and holds all three
// stable until the cycle ready is high; that cycle (valid && ready) is the
// transfer. ready is combinational from valid and never high without valid.
interface rf_write_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Owns the single write port of the register file. After reset (and on a
// clear pulse) it sweeps zeros into every register, then arbitrates between
// the ALU (req0) and load (req1) writeback paths with round-robin priority.
// wr_en / wr_data are registered and drive the register array directly.
// ADDR_W must satisfy 2**ADDR_W == NREG.
module rf_write_arbiter #(
  parameter int DATA_W  = 16,
  parameter int NREG    = 16,
  parameter int ADDR_W  = 4,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  rf_write_arbiter_if.slave req,
  output logic [NREG-1:0]   wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              init_done,
  output logic              dbg_state
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt;
  logic              rr;        // 0: req0 wins a tie, 1: req1 wins a tie
  logic              grant0, grant1;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign dbg_state      = state_q;
  assign req.req0_ready = grant0;
  assign req.req1_ready = grant1;

  // Next state and grants; grants only exist in RUN and are mutually exclusive.
  always_comb begin
    state_d  = state_q;
    grant0   = 1'b0;
    grant1   = 1'b0;
    sel_addr = req.req0_addr;
    sel_data = req.req0_data;
    if (state_q == S_INIT) begin
      if (cnt == LAST) state_d = S_RUN;
    end else begin
      if (req.req0_valid && (!req.req1_valid || !rr)) begin
        grant0 = 1'b1;
      end else if (req.req1_valid) begin
        grant1 = 1'b1;
      end
      if (grant1) begin
        sel_addr = req.req1_addr;
        sel_data = req.req1_data;
      end
      if (clear) state_d = S_INIT;
    end
  end

  // State register, sweep counter, RR pointer and the registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_INIT;
      cnt       <= '0;
      rr        <= 1'b0;
      wr_en     <= '0;
      wr_data   <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_done <= (state_d == S_RUN);
      if (state_q == S_INIT) begin
        // Sweep includes R0 regardless of ZERO_R0; cnt wraps to 0 after LAST.
        wr_en   <= NREG'(1) << cnt;
        wr_data <= '0;
        cnt     <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        if (grant0 || grant1) begin
          // Point at the requester that did not win this transfer.
          rr      <= grant0;
          wr_data <= sel_data;
          if ((ZERO_R0 != 0) && (sel_addr == '0)) wr_en <= '0;
          else                                    wr_en <= NREG'(1) << sel_addr;
        end else begin
          wr_en <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: init sweep, single writes, round-robin,
// dropped R0 writes, clear and mid-sweep reset.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [15:0] wr_en;
  logic [15:0] wr_data;
  logic        init_done;
  logic        dbg_state;

  int check_cnt = 0;
  int pass_cnt  = 0;

  rf_write_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  rf_write_arbiter #(.DATA_W(16), .NREG(16), .ADDR_W(4), .ZERO_R0(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .req       (bus),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .init_done (init_done),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear          = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_data  = '0;
  endtask

  // Checks 16 sweep edges: one-hot walk, zero data, init_done on the last edge.
  task automatic check_sweep(input string tag);
    for (int k = 0; k < 16; k++) begin
      check_cnt++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
        $display("FAIL %s_ready k=%0d: got %b required 00", tag, k, {bus.req0_ready, bus.req1_ready});
      else pass_cnt++;
      step();
      check_cnt++;
      if (wr_en !== (16'h0001 << k) || wr_data !== 16'h0000)
        $display("FAIL %s_wr k=%0d: got en=%h data=%h required en=%h data=0000", tag, k, wr_en, wr_data, 16'h0001 << k);
      else pass_cnt++;
      check_cnt++;
      if (init_done !== (k == 15))
        $display("FAIL %s_init_done k=%0d: got %b required %b", tag, k, init_done, (k == 15));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cnt++;
    if (wr_en !== 16'h0 || wr_data !== 16'h0 || init_done !== 1'b0 || dbg_state !== 1'b0)
      $display("FAIL reset_vals: got en=%h data=%h done=%b st=%b required 0", wr_en, wr_data, init_done, dbg_state);
    else pass_cnt++;
    // Requests are held valid through the sweep to show ready stays low.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    rst = 1'b1;
    check_sweep("init");
    idle_inputs();
    check_cnt++;
    if (dbg_state !== 1'b1) $display("FAIL init_state: got %b required 1", dbg_state);
    else pass_cnt++;
  endtask

  task automatic test_single_req0();
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd5; bus.req0_data = 16'hBEEF;
    #1;
    check_cnt++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
      $display("FAIL req0_ready: got %b required 10", {bus.req0_ready, bus.req1_ready});
    else pass_cnt++;
    step();
    idle_inputs();
    check_cnt++;
    if (wr_en !== 16'h0020 || wr_data !== 16'hBEEF)
      $display("FAIL req0_write: got en=%h data=%h required en=0020 data=beef", wr_en, wr_data);
    else pass_cnt++;
    step();
    check_cnt++;
    if (wr_en !== 16'h0000 || wr_data !== 16'hBEEF)
      $display("FAIL req0_idle: got en=%h data=%h required en=0000 data=beef", wr_en, wr_data);
    else pass_cnt++;
  endtask

  task automatic test_zero_r0();
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd0; bus.req1_data = 16'hFFFF;
    #1;
    check_cnt++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01)
      $display("FAIL r0_ready: got %b required 01", {bus.req0_ready, bus.req1_ready});
    else pass_cnt++;
    step();
    idle_inputs();
    check_cnt++;
    if (wr_en !== 16'h0000 || wr_data !== 16'hFFFF)
      $display("FAIL r0_drop: got en=%h data=%h required en=0000 data=ffff", wr_en, wr_data);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic [15:0] exp_en;
    logic [15:0] exp_dat;
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd3; bus.req0_data = 16'h1111;
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd9; bus.req1_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_en  = (i % 2 == 0) ? 16'h0008 : 16'h0200;
      exp_dat = (i % 2 == 0) ? 16'h1111 : 16'h2222;
      #1;
      check_cnt++;
      if ({bus.req0_ready, bus.req1_ready} !== exp_rdy)
        $display("FAIL rr_ready i=%0d: got %b required %b", i, {bus.req0_ready, bus.req1_ready}, exp_rdy);
      else pass_cnt++;
      step();
      check_cnt++;
      if (wr_en !== exp_en || wr_data !== exp_dat)
        $display("FAIL rr_write i=%0d: got en=%h data=%h required en=%h data=%h", i, wr_en, wr_data, exp_en, exp_dat);
      else pass_cnt++;
    end
    idle_inputs();
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd1; bus.req0_data = 16'h0101;
    step();
    idle_inputs();
    check_cnt++;
    if (wr_en !== 16'h0002 || wr_data !== 16'h0101)
      $display("FAIL addr1_write: got en=%h data=%h required en=0002 data=0101", wr_en, wr_data);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd2; bus.req0_data = 16'h00AA;
    clear = 1'b1;
    #1;
    check_cnt++;
    if (bus.req0_ready !== 1'b1) $display("FAIL clear_ready: got %b required 1", bus.req0_ready);
    else pass_cnt++;
    step();
    idle_inputs();
    check_cnt++;
    if (wr_en !== 16'h0004 || wr_data !== 16'h00AA || init_done !== 1'b0)
      $display("FAIL clear_write: got en=%h data=%h done=%b required en=0004 data=00aa done=0", wr_en, wr_data, init_done);
    else pass_cnt++;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    clear = 1'b1;   // ignored during the sweep
    check_sweep("clear");
    idle_inputs();
  endtask

  task automatic test_reset_mid_sweep();
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (7) step();
    check_cnt++;
    if (wr_en !== 16'h0040) $display("FAIL pre_reset: got en=%h required 0040", wr_en);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    check_cnt++;
    if (wr_en !== 16'h0 || wr_data !== 16'h0 || init_done !== 1'b0)
      $display("FAIL async_reset: got en=%h data=%h done=%b required 0", wr_en, wr_data, init_done);
    else pass_cnt++;
    step();
    rst = 1'b1;
    check_sweep("restart");
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_zero_r0();
    test_round_robin();
    test_clear();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
